obi_sram_arbiter: RTL and testbench



---
 rtl/obi_sram_arbiter.sv | 124 ++++++++++++
 tb/tb_obi_sram_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_sram_arbiter.sv
// obi_sram_arbiter
// Two-port OBI arbiter in front of a synchronous single-port SRAM with
// 1-cycle read latency. Data requests win contention by fixed priority.
// Define OBI_ARB_STARVE_GUARD_EN to build the starve counter that forces an
// instruction grant after STARVE_LIMIT consecutive data wins against a
// waiting fetch. Without the macro, data always wins contention.
module obi_sram_arbiter #(
    parameter int RAM_ADDR_WIDTH = 20,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,

    input  logic                      instr_req_i,
    output logic                      instr_gnt_o,
    output logic                      instr_rvalid_o,
    input  logic [31:0]               instr_addr_i,
    output logic [31:0]               instr_rdata_o,

    input  logic                      data_req_i,
    output logic                      data_gnt_o,
    output logic                      data_rvalid_o,
    input  logic [31:0]               data_addr_i,
    input  logic [3:0]                data_be_i,
    input  logic                      data_we_i,
    input  logic [31:0]               data_wdata_i,
    output logic [31:0]               data_rdata_o,

    output logic                      mem_en_o,
    output logic                      mem_we_o,
    output logic [RAM_ADDR_WIDTH-3:0] mem_addr_o,
    output logic [3:0]                mem_be_o,
    output logic [31:0]               mem_wdata_o,
    input  logic [31:0]               mem_rdata_i
);

    logic resp_instr_q;
    logic resp_data_q;
    logic resp_we_q;
    logic starve_hit;
    logic unused_bits;

`ifdef OBI_ARB_STARVE_GUARD_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt_q;

    // Count data wins that stall a waiting fetch, saturating at the limit
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            starve_cnt_q <= 4'd0;
        end else if (instr_gnt_o || !instr_req_i) begin
            starve_cnt_q <= 4'd0;
        end else if (data_gnt_o && (starve_cnt_q != LIMIT)) begin
            starve_cnt_q <= starve_cnt_q + 4'd1;
        end
    end

    assign starve_hit = (starve_cnt_q == LIMIT);

    assign unused_bits = ^{instr_addr_i[31:RAM_ADDR_WIDTH], instr_addr_i[1:0],
                           data_addr_i[31:RAM_ADDR_WIDTH], data_addr_i[1:0]};
`else
    assign starve_hit = 1'b0;

    // The limit has no meaning without the guard; it is folded in here only
    // so the parameter is still referenced.
    assign unused_bits = ^{instr_addr_i[31:RAM_ADDR_WIDTH], instr_addr_i[1:0],
                           data_addr_i[31:RAM_ADDR_WIDTH], data_addr_i[1:0],
                           4'(STARVE_LIMIT)};
`endif

    // Pick at most one winner per cycle; fetch wins contention only once the guard trips
    always_comb begin
        instr_gnt_o = 1'b0;
        data_gnt_o  = 1'b0;
        if (!rst_i) begin
            if (data_req_i && !(instr_req_i && starve_hit)) begin
                data_gnt_o = 1'b1;
            end else if (instr_req_i) begin
                instr_gnt_o = 1'b1;
            end
        end
    end

    // Steer the winning port onto the SRAM; an idle cycle drives all zeros
    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_be_o    = 4'h0;
        mem_wdata_o = 32'h0;
        if (data_gnt_o) begin
            mem_en_o    = 1'b1;
            mem_we_o    = data_we_i;
            mem_addr_o  = data_addr_i[RAM_ADDR_WIDTH-1:2];
            mem_be_o    = data_be_i;
            mem_wdata_o = data_wdata_i;
        end else if (instr_gnt_o) begin
            mem_en_o    = 1'b1;
            mem_addr_o  = instr_addr_i[RAM_ADDR_WIDTH-1:2];
            mem_be_o    = 4'hF;
        end
    end

    // Remember who owns the SRAM response arriving next cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            resp_instr_q <= 1'b0;
            resp_data_q  <= 1'b0;
            resp_we_q    <= 1'b0;
        end else begin
            resp_instr_q <= instr_gnt_o;
            resp_data_q  <= data_gnt_o;
            resp_we_q    <= data_gnt_o & data_we_i;
        end
    end

    assign instr_rvalid_o = resp_instr_q;
    assign data_rvalid_o  = resp_data_q;
    assign instr_rdata_o  = resp_instr_q ? mem_rdata_i : 32'h0;
    assign data_rdata_o   = (resp_data_q && !resp_we_q) ? mem_rdata_i : 32'h0;

endmodule

// File: tb/tb_obi_sram_arbiter.sv
// tb_obi_sram_arbiter
// Scoreboard bench for obi_sram_arbiter with a behavioural SRAM. Expected
// responses are queued per port when a grant is expected and checked when
// the response cycle arrives. Starvation expectations follow
// OBI_ARB_STARVE_GUARD_EN.
module tb_obi_sram_arbiter;

    localparam int RAM_ADDR_WIDTH = 20;
    localparam int STARVE_LIMIT   = 4;

`ifdef OBI_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic                      clk_i = 1'b0;
    logic                      rst_i;
    logic                      instr_req_i;
    logic                      instr_gnt_o;
    logic                      instr_rvalid_o;
    logic [31:0]               instr_addr_i;
    logic [31:0]               instr_rdata_o;
    logic                      data_req_i;
    logic                      data_gnt_o;
    logic                      data_rvalid_o;
    logic [31:0]               data_addr_i;
    logic [3:0]                data_be_i;
    logic                      data_we_i;
    logic [31:0]               data_wdata_i;
    logic [31:0]               data_rdata_o;
    logic                      mem_en_o;
    logic                      mem_we_o;
    logic [RAM_ADDR_WIDTH-3:0] mem_addr_o;
    logic [3:0]                mem_be_o;
    logic [31:0]               mem_wdata_o;
    logic [31:0]               mem_rdata_i;

    typedef struct {
        int          cycle;
        logic [31:0] data;
    } exp_t;

    exp_t        instrQ[$];
    exp_t        dataQ[$];
    logic [31:0] sram   [0:1023];
    logic [31:0] refMem [0:1023];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;

    obi_sram_arbiter #(
        .RAM_ADDR_WIDTH (RAM_ADDR_WIDTH),
        .STARVE_LIMIT   (STARVE_LIMIT)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .instr_req_i    (instr_req_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_addr_i   (instr_addr_i),
        .instr_rdata_o  (instr_rdata_o),
        .data_req_i     (data_req_i),
        .data_gnt_o     (data_gnt_o),
        .data_rvalid_o  (data_rvalid_o),
        .data_addr_i    (data_addr_i),
        .data_be_i      (data_be_i),
        .data_we_i      (data_we_i),
        .data_wdata_i   (data_wdata_i),
        .data_rdata_o   (data_rdata_o),
        .mem_en_o       (mem_en_o),
        .mem_we_o       (mem_we_o),
        .mem_addr_o     (mem_addr_o),
        .mem_be_o       (mem_be_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_rdata_i    (mem_rdata_i)
    );

    // Free-running clock
    always #5 clk_i = ~clk_i;

    // Behavioural SRAM: byte-masked write, 1-cycle read, junk when not reading
    always @(posedge clk_i) begin
        if (mem_en_o && mem_we_o) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be_o[b]) begin
                    sram[mem_addr_o[9:0]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
                end
            end
            mem_rdata_i <= 32'hA5A5_A5A5;
        end else if (mem_en_o) begin
            mem_rdata_i <= sram[mem_addr_o[9:0]];
        end else begin
            mem_rdata_i <= 32'hA5A5_A5A5;
        end
    end

    function automatic logic [9:0] wordIdx(input logic [31:0] addr);
        return addr[11:2];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
                     tag, actual, expected, cyc);
        end
    endtask

    // Compare any response due this cycle, or require silence on the port
    task automatic checkResponses();
        if (instrQ.size() > 0 && instrQ[0].cycle == cyc) begin
            checkOutput("instr_rvalid", 32'(instr_rvalid_o), 32'd1);
            checkOutput("instr_rdata", instr_rdata_o, instrQ[0].data);
            void'(instrQ.pop_front());
        end else begin
            checkOutput("instr_rvalid_idle", 32'(instr_rvalid_o), 32'd0);
        end
        if (dataQ.size() > 0 && dataQ[0].cycle == cyc) begin
            checkOutput("data_rvalid", 32'(data_rvalid_o), 32'd1);
            checkOutput("data_rdata", data_rdata_o, dataQ[0].data);
            void'(dataQ.pop_front());
        end else begin
            checkOutput("data_rvalid_idle", 32'(data_rvalid_o), 32'd0);
        end
    endtask

    // Drive one cycle of requests, check grants and SRAM drive, queue responses
    task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr,
                                 input logic dreq, input logic [31:0] daddr,
                                 input logic dwe, input logic [3:0] dbe,
                                 input logic [31:0] dwdata,
                                 input logic expIgnt, input logic expDgnt);
        exp_t e;
        instr_req_i  = ireq;
        instr_addr_i = iaddr;
        data_req_i   = dreq;
        data_addr_i  = daddr;
        data_we_i    = dwe;
        data_be_i    = dbe;
        data_wdata_i = dwdata;
        @(negedge clk_i);
        checkResponses();
        checkOutput("instr_gnt", 32'(instr_gnt_o), 32'(expIgnt));
        checkOutput("data_gnt", 32'(data_gnt_o), 32'(expDgnt));
        e.cycle = cyc + 1;
        if (expDgnt) begin
            checkOutput("mem_en_data", 32'(mem_en_o), 32'd1);
            checkOutput("mem_we_data", 32'(mem_we_o), 32'(dwe));
            checkOutput("mem_addr_data", 32'(mem_addr_o), {14'h0, daddr[19:2]});
            checkOutput("mem_be_data", 32'(mem_be_o), 32'(dbe));
            checkOutput("mem_wdata_data", mem_wdata_o, dwdata);
            if (dwe) begin
                for (int b = 0; b < 4; b++) begin
                    if (dbe[b]) refMem[wordIdx(daddr)][8*b +: 8] = dwdata[8*b +: 8];
                end
                e.data = 32'h0;
            end else begin
                e.data = refMem[wordIdx(daddr)];
            end
            dataQ.push_back(e);
        end else if (expIgnt) begin
            checkOutput("mem_en_instr", 32'(mem_en_o), 32'd1);
            checkOutput("mem_we_instr", 32'(mem_we_o), 32'd0);
            checkOutput("mem_addr_instr", 32'(mem_addr_o), {14'h0, iaddr[19:2]});
            checkOutput("mem_be_instr", 32'(mem_be_o), 32'hF);
            e.data = refMem[wordIdx(iaddr)];
            instrQ.push_back(e);
        end else begin
            checkOutput("mem_en_idle", 32'(mem_en_o), 32'd0);
            checkOutput("mem_be_idle", 32'(mem_be_o), 32'd0);
            checkOutput("mem_addr_idle", 32'(mem_addr_o), 32'd0);
        end
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
    endtask

    // Hold reset with both requests asserted; everything must stay quiet
    task automatic applyReset(input int cycles);
        rst_i       = 1'b1;
        instr_req_i = 1'b1;
        data_req_i  = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk_i);
            checkOutput("rst_instr_gnt", 32'(instr_gnt_o), 32'd0);
            checkOutput("rst_data_gnt", 32'(data_gnt_o), 32'd0);
            checkOutput("rst_mem_en", 32'(mem_en_o), 32'd0);
            checkOutput("rst_data_rvalid", 32'(data_rvalid_o), 32'd0);
            checkOutput("rst_instr_rvalid", 32'(instr_rvalid_o), 32'd0);
            checkOutput("rst_data_rdata", data_rdata_o, 32'd0);
            checkOutput("rst_instr_rdata", instr_rdata_o, 32'd0);
            @(posedge clk_i);
            #1;
            cyc++;
        end
        instrQ.delete();
        dataQ.delete();
        instr_req_i = 1'b0;
        data_req_i  = 1'b0;
        rst_i       = 1'b0;
    endtask

    initial begin
        int          dIdx;
        int          nCyc;
        logic        expI;
        logic [31:0] daddr;

        for (int i = 0; i < 1024; i++) begin
            sram[i] = {16'(i) ^ 16'h5A5A, ~16'(i)};
        end
        sram[10'h040] = 32'hDEAD_BEEF;
        sram[10'h041] = 32'hCAFE_F00D;
        sram[10'h080] = 32'h0000_0000;
        sram[10'h010] = 32'h0BAD_F00D;
        for (int i = 0; i < 1024; i++) refMem[i] = sram[i];

        instr_addr_i = 32'h0;
        data_addr_i  = 32'h0;
        data_we_i    = 1'b0;
        data_be_i    = 4'h0;
        data_wdata_i = 32'h0;
        applyReset(3);

        // Instruction read in the first cycle out of reset
        applyStimulus(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0);
        idleCycle();

        // Partial write then read-back of the same word in the next cycle
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h200, 1'b1, 4'b0010, 32'h1122_3344, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h200, 1'b0, 4'hF, 32'h0, 1'b0, 1'b1);
        idleCycle();
        checkOutput("rmw_word", refMem[10'h080], 32'h0000_3300);

        // Contention: data first, instruction the following cycle
        applyStimulus(1'b1, 32'h100, 1'b1, 32'h104, 1'b0, 4'hF, 32'h0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0);
        idleCycle();

        // Continuous contention: guard lets fetch in after the limit, otherwise never
        dIdx = 0;
        nCyc = GUARD ? STARVE_LIMIT + 1 : 20;
        for (int i = 0; i < nCyc; i++) begin
            expI  = GUARD && (i == STARVE_LIMIT);
            daddr = 32'h300 + 32'(4 * dIdx);
            applyStimulus(1'b1, 32'h180, 1'b1, daddr, (dIdx % 3) == 0,
                          4'(dIdx + 1), 32'h0F0F_0000 + 32'(dIdx), expI, !expI);
            if (!expI) dIdx++;
        end
        daddr = 32'h300 + 32'(4 * dIdx);
        applyStimulus(!GUARD, 32'h180, GUARD, daddr, 1'b0, 4'hF, 32'h0, !GUARD, GUARD);
        idleCycle();

        // Aliasing: bit 20 and above are ignored
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h0010_0040, 1'b0, 4'hF, 32'h0, 1'b0, 1'b1);
        idleCycle();
        checkOutput("alias_word", refMem[10'h010], 32'h0BAD_F00D);

        // Reset landing on a pending data response drops it for good
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h104, 1'b0, 4'hF, 32'h0, 1'b0, 1'b1);
        applyReset(2);
        idleCycle();
        idleCycle();
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h104, 1'b0, 4'hF, 32'h0, 1'b0, 1'b1);
        idleCycle();

        checkOutput("queue_drain", 32'(instrQ.size() + dataQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
